// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer / hazard controller.
//   state_e   : FSM state encodings (also exported on o_state)
//   FWD_*     : EX-stage operand select codes
//   NOP_INSTR : instruction word loaded on flush / bubble
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

endpackage

// File: rtl/pipeline_ctrl_hazard_fwd_unit.sv
// Combinational hazard detection and operand forwarding.
//   id_rs_i/id_rt_i         : ID-stage sources
//   ex_mem_read_i, ex_rs_i,
//   ex_rt_i                 : EX-stage instruction (load destination is ex_rt_i)
//   mem_reg_write_i/mem_rd_i: EX/MEM writer
//   wb_reg_write_i/wb_rd_i  : MEM/WB writer
//   load_use_o              : ID instruction needs a load still in EX
//   fwd_a_o/fwd_b_o         : operand select for ex_rs / ex_rt
module hazard_fwd_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR = 5
) (
  input  logic [NB_ADDR-1:0] id_rs_i,
  input  logic [NB_ADDR-1:0] id_rt_i,
  input  logic               ex_mem_read_i,
  input  logic [NB_ADDR-1:0] ex_rs_i,
  input  logic [NB_ADDR-1:0] ex_rt_i,
  input  logic               mem_reg_write_i,
  input  logic [NB_ADDR-1:0] mem_rd_i,
  input  logic               wb_reg_write_i,
  input  logic [NB_ADDR-1:0] wb_rd_i,
  output logic               load_use_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o
);

  // EX/MEM is the younger result, so it beats MEM/WB; $0 is hard-wired zero.
  function automatic logic [1:0] fwd_sel(input logic [NB_ADDR-1:0] src,
                                         input logic               mem_we,
                                         input logic [NB_ADDR-1:0] mem_rd,
                                         input logic               wb_we,
                                         input logic [NB_ADDR-1:0] wb_rd);
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rt_i != '0) &&
                 ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    fwd_a_o    = fwd_sel(ex_rs_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
    fwd_b_o    = fwd_sel(ex_rt_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer and hazard controller for the 5-stage MIPS pipeline.
//   i_clock, i_reset             : clock, synchronous active-high reset
//   i_run, i_step                : debug-unit pulses (free-run / single cycle) from IDLE
//   i_halt_instr                 : halt opcode in ID, starts the drain
//   i_branch_taken               : taken branch/jump, flushes IF/ID
//   i_id_*, i_ex_*, i_mem_*, i_wb_*: pipeline register fields for hazards / forwarding
//   o_valid, o_pc_enable, o_ifid_enable, o_flush_ifid, o_bubble: stage controls (combinational)
//   o_fwd_a, o_fwd_b             : EX operand selects (combinational, all states)
//   o_halted, o_state            : registered status
//   o_cycle_count                : registered count of cycles with o_valid=1
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR      = 5,
  parameter int unsigned NB_CNT       = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_halt_instr,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_rs,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic               i_mem_reg_write,
  input  logic [NB_ADDR-1:0] i_mem_rd,
  input  logic               i_wb_reg_write,
  input  logic [NB_ADDR-1:0] i_wb_rd,
  output logic               o_valid,
  output logic               o_pc_enable,
  output logic               o_ifid_enable,
  output logic               o_flush_ifid,
  output logic               o_bubble,
  output logic [1:0]         o_fwd_a,
  output logic [1:0]         o_fwd_b,
  output logic               o_halted,
  output logic [2:0]         o_state,
  output logic [NB_CNT-1:0]  o_cycle_count
);

  localparam int unsigned NbDrain = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NbDrain-1:0] DrainLoad = NbDrain'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NbDrain-1:0]  drain_cnt_q, drain_cnt_d;
  logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                halted_q;
  logic                load_use;

  hazard_fwd_unit #(
    .NB_ADDR(NB_ADDR)
  ) u_hazard_fwd (
    .id_rs_i        (i_id_rs),
    .id_rt_i        (i_id_rt),
    .ex_mem_read_i  (i_ex_mem_read),
    .ex_rs_i        (i_ex_rs),
    .ex_rt_i        (i_ex_rt),
    .mem_reg_write_i(i_mem_reg_write),
    .mem_rd_i       (i_mem_rd),
    .wb_reg_write_i (i_wb_reg_write),
    .wb_rd_i        (i_wb_rd),
    .load_use_o     (load_use),
    .fwd_a_o        (o_fwd_a),
    .fwd_b_o        (o_fwd_b)
  );

  // Next state and drain counter.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      StIdle: begin
        if (i_run) begin
          state_d = StRun;
        end else if (i_step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (i_halt_instr) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end
      end
      StStep: begin
        if (i_halt_instr) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Stage controls act in the current cycle. Drain overrides hazards; a taken branch
  // discards the ID instruction, so a coincident load-use stall is moot.
  always_comb begin
    o_valid       = 1'b0;
    o_pc_enable   = 1'b0;
    o_ifid_enable = 1'b0;
    o_flush_ifid  = 1'b0;
    o_bubble      = 1'b0;
    case (state_q)
      StRun, StStep: begin
        o_valid       = 1'b1;
        o_pc_enable   = 1'b1;
        o_ifid_enable = 1'b1;
        if (i_branch_taken) begin
          o_flush_ifid = 1'b1;
        end else if (load_use) begin
          o_pc_enable   = 1'b0;
          o_ifid_enable = 1'b0;
          o_bubble      = 1'b1;
        end
      end
      StDrain: begin
        o_valid       = 1'b1;
        o_ifid_enable = 1'b1;
        o_flush_ifid  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cycle_cnt_d = cycle_cnt_q + NB_CNT'(o_valid);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      halted_q    <= (state_d == StHalted);
    end
  end

  assign o_state       = state_q;
  assign o_halted      = halted_q;
  assign o_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        run, step, halt_instr, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic        ex_mem_read, mem_reg_write, wb_reg_write;
  logic        valid, pc_en, ifid_en, flush, bubble, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .NB_ADDR     (5),
    .NB_CNT      (32),
    .DRAIN_CYCLES(3)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_run          (run),
    .i_step         (step),
    .i_halt_instr   (halt_instr),
    .i_branch_taken (branch_taken),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_rs        (ex_rs),
    .i_ex_rt        (ex_rt),
    .i_mem_reg_write(mem_reg_write),
    .i_mem_rd       (mem_rd),
    .i_wb_reg_write (wb_reg_write),
    .i_wb_rd        (wb_rd),
    .o_valid        (valid),
    .o_pc_enable    (pc_en),
    .o_ifid_enable  (ifid_en),
    .o_flush_ifid   (flush),
    .o_bubble       (bubble),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_halted       (halted),
    .o_state        (state),
    .o_cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic       ld;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       mem_we;
    logic [4:0] mem_rd;
    logic       wb_we;
    logic [4:0] wb_rd;
    logic       e_pc, e_ifid, e_flush, e_bubble;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    run = 0; step = 0; halt_instr = 0; branch_taken = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0;
    ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  // Leaves the bench at a negedge with the DUT in IDLE.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // IDLE -> RUN; returns at the negedge of the first RUN cycle.
  task automatic start_run();
    run = 1;
    @(negedge clk);
    run = 0;
  endtask

  task automatic set_vec(input vec_t v);
    branch_taken = v.br; ex_mem_read = v.ld;
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    mem_reg_write = v.mem_we; mem_rd = v.mem_rd;
    wb_reg_write = v.wb_we; wb_rd = v.wb_rd;
  endtask

  initial begin
    //        br ld idrs idrt exrs exrt mwe mrd wwe wrd  pc ifid fl bub fa     fb
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{0, 1, 5, 2, 0, 5, 0, 0, 0, 0,           0, 0, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 2'b00, 2'b00};
    vecs[3]  = '{0, 1, 3, 5, 0, 5, 0, 0, 0, 0,           0, 0, 0, 1, 2'b00, 2'b00};
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{1, 1, 5, 0, 0, 5, 0, 0, 0, 0,           1, 1, 1, 0, 2'b00, 2'b00};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 1, 0, 2'b00, 2'b00};
    vecs[7]  = '{0, 0, 5, 0, 0, 5, 0, 0, 0, 0,           1, 1, 0, 0, 2'b00, 2'b00};
    vecs[8]  = '{0, 0, 0, 0, 7, 3, 1, 7, 1, 7,           1, 1, 0, 0, 2'b10, 2'b00};
    vecs[9]  = '{0, 0, 0, 0, 7, 3, 0, 7, 1, 7,           1, 1, 0, 0, 2'b01, 2'b00};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0,           1, 1, 0, 0, 2'b00, 2'b00};
    vecs[11] = '{0, 0, 0, 0, 4, 9, 1, 9, 1, 4,           1, 1, 0, 0, 2'b01, 2'b10};

    do_reset();
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_count", cycle_count, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_pc_en", 32'(pc_en), 32'd0);

    // Forwarding and enables in IDLE, with a branch and load-use present.
    ex_rs = 7; mem_rd = 7; mem_reg_write = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    branch_taken = 1;
    #1;
    chk("idle_fwd_a", 32'(fwd_a), 32'b10);
    chk("idle_flush", 32'(flush), 32'd0);
    chk("idle_bubble", 32'(bubble), 32'd0);
    chk("idle_ifid", 32'(ifid_en), 32'd0);
    clear_inputs();

    // Run pulse.
    @(negedge clk);
    start_run();
    #1;
    chk("run_state", 32'(state), 32'd1);
    chk("run_valid", 32'(valid), 32'd1);
    chk("run_count0", cycle_count, 32'd0);
    @(negedge clk);
    chk("run_count1", cycle_count, 32'd1);

    // Single step.
    do_reset();
    step = 1;
    @(negedge clk);
    step = 0;
    #1;
    chk("step_state", 32'(state), 32'd2);
    chk("step_valid", 32'(valid), 32'd1);
    @(negedge clk);
    #1;
    chk("step_back_idle", 32'(state), 32'd0);
    chk("step_valid_off", 32'(valid), 32'd0);
    chk("step_count", cycle_count, 32'd1);
    @(negedge clk);
    chk("step_count_hold", cycle_count, 32'd1);

    // Run and step together: run wins.
    do_reset();
    run = 1; step = 1;
    @(negedge clk);
    run = 0; step = 0;
    #1;
    chk("run_beats_step", 32'(state), 32'd1);

    // Table of hazard/forwarding vectors in RUN.
    do_reset();
    start_run();
    for (int i = 0; i < 12; i++) begin
      set_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("v%0d_pc_en", i), 32'(pc_en), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_ifid", i), 32'(ifid_en), 32'(vecs[i].e_ifid));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_bubble", i), 32'(bubble), 32'(vecs[i].e_bubble));
      chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].e_fa));
      chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].e_fb));
      @(negedge clk);
    end
    clear_inputs();

    // Halt in RUN: 3 drain cycles, then HALTED. Count = 1 RUN + 3 DRAIN.
    do_reset();
    start_run();
    halt_instr = 1;
    #1;
    chk("halt_run_valid", 32'(valid), 32'd1);
    @(negedge clk);
    halt_instr = 0;
    branch_taken = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain%0d_state", i), 32'(state), 32'd3);
      chk($sformatf("drain%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("drain%0d_pc_en", i), 32'(pc_en), 32'd0);
      chk($sformatf("drain%0d_flush", i), 32'(flush), 32'd1);
      chk($sformatf("drain%0d_bubble", i), 32'(bubble), 32'd0);
      chk($sformatf("drain%0d_halted", i), 32'(halted), 32'd0);
      @(negedge clk);
    end
    clear_inputs();
    #1;
    chk("halted_state", 32'(state), 32'd4);
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_valid", 32'(valid), 32'd0);
    chk("halted_pc_en", 32'(pc_en), 32'd0);
    chk("halted_count", cycle_count, 32'd4);
    run = 1; step = 1;
    @(negedge clk);
    run = 0; step = 0;
    @(negedge clk);
    chk("halted_ignore_run", 32'(state), 32'd4);
    chk("halted_count_hold", cycle_count, 32'd4);

    // Reset in the middle of a drain.
    do_reset();
    start_run();
    halt_instr = 1;
    @(negedge clk);
    halt_instr = 0;
    chk("drain_entry", 32'(state), 32'd3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("drain_reset_state", 32'(state), 32'd0);
    chk("drain_reset_count", cycle_count, 32'd0);
    chk("drain_reset_halted", 32'(halted), 32'd0);

    // Halt seen during a single step.
    do_reset();
    step = 1;
    @(negedge clk);
    step = 0;
    halt_instr = 1;
    @(negedge clk);
    halt_instr = 0;
    chk("step_halt_drain", 32'(state), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
